input_unit: RTL and testbench

Front end of the datapath's user-input side and the counterpart of the display unit. It synchronizes and debounces the active-low run key and latches the 10 switches as an instruction word. It issues a one-cycle RUN request to the controller and holds BUSY until the controller reports DONE. While busy, it drives the live switch value onto the shared 10-bit bus whenever the controller asserts EXTRN.

---
 rtl/input_unit.sv | 157 +++++++++++++++
 tb/tb_input_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/input_unit.sv
// input_unit
//   User-input front end of the datapath, the counterpart of the display unit.
//   It synchronizes and debounces the active-low run key and latches the
//   switches as an instruction word on each accepted press. It then issues a
//   one-cycle RUN request and holds BUSY until the controller reports DONE.
//   While the controller is running, it places the live switch value on the
//   shared bus whenever EXTRN is asserted.
//
// Parameters
//   DEB_CYCLES  consecutive stable synchronized samples needed to change the
//               debounced key state (>= 1). Use 4 for simulation and 250000
//               on the board.
//
// Ports
//   CLK      in   1   system clock, rising edge
//   RSTb     in   1   synchronous active-low reset
//   SW       in  10   raw switches (asynchronous)
//   KEYb     in   1   raw run key, active-low (asynchronous, bouncing)
//   EXTRN    in   1   controller wants external data on the bus
//   DONE     in   1   controller end-of-instruction
//   INSTR    out 10   instruction word latched at the accepted press
//   RUN      out  1   one-cycle start request
//   BUSY     out  1   high from issue until DONE is accepted
//   BUS_OUT  out 10   data for the shared bus (zero when not driving)
//   BUS_EN   out  1   bus-drive enable
//   OVR      out  1   sticky: a press was dropped while busy

module input_unit #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RSTb,
  input  logic [9:0] SW,
  input  logic       KEYb,
  input  logic       EXTRN,
  input  logic       DONE,
  output logic [9:0] INSTR,
  output logic       RUN,
  output logic       BUSY,
  output logic [9:0] BUS_OUT,
  output logic       BUS_EN,
  output logic       OVR
);

  localparam int             CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t           state;
  state_t           next_state;

  logic             key_m;
  logic             key_s;
  logic [9:0]       sw_m;
  logic [9:0]       sw_s;

  logic             db;
  logic             db_last;
  logic [CNT_W-1:0] cnt;
  logic             press;

  // Two-flop synchronizers; the key idles released (1).
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      key_m <= KEYb;
      key_s <= key_m;
      sw_m  <= SW;
      sw_s  <= sw_m;
    end
  end

  // Debouncer: db only follows key_s after DEB_CYCLES consecutive differing
  // samples; any agreeing sample restarts the count. The press pulse is a
  // registered falling-edge detect of db, so only a debounced press (1->0)
  // produces it, never a release.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      db      <= 1'b1;
      db_last <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      db_last <= db;
      press   <= db_last & ~db;
      if (key_s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= key_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // State register plus the instruction latch and overrun flag. A press is
  // only accepted in IDLE; anywhere else it is dropped and recorded in OVR,
  // which clears when the next press is accepted.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state <= IDLE;
      INSTR <= '0;
      OVR   <= 1'b0;
    end else begin
      state <= next_state;
      if (press) begin
        if (state == IDLE) begin
          INSTR <= sw_s;
          OVR   <= 1'b0;
        end else begin
          OVR   <= 1'b1;
        end
      end
    end
  end

  // Next state and outputs. DONE is only honoured in WAIT, so a DONE that
  // coincides with the RUN cycle cannot skip the wait.
  always_comb begin
    next_state = state;
    RUN        = 1'b0;
    BUSY       = 1'b0;
    BUS_EN     = 1'b0;
    BUS_OUT    = '0;

    case (state)
      IDLE: begin
        if (press) next_state = ISSUE;
      end
      ISSUE: begin
        RUN        = 1'b1;
        BUSY       = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        BUSY   = 1'b1;
        BUS_EN = EXTRN;
        if (EXTRN) BUS_OUT = sw_s;
        if (DONE)  next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_input_unit.sv
// tb_input_unit
//   Self-checking bench for input_unit with DEB_CYCLES = 4. Each accepted
//   press pushes its switch value onto a scoreboard queue; a monitor pops it
//   whenever RUN appears and compares INSTR. Directed checks cover reset,
//   bounce rejection, press timing, bus drive, overrun, DONE handling and
//   reset in the middle of an instruction.

module tb_input_unit;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RSTb;
  logic [9:0] SW;
  logic       KEYb;
  logic       EXTRN;
  logic       DONE;
  logic [9:0] INSTR;
  logic       RUN;
  logic       BUSY;
  logic [9:0] BUS_OUT;
  logic       BUS_EN;
  logic       OVR;

  int         check_count = 0;
  int         fail_count  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] sb_exp;

  input_unit #(.DEB_CYCLES(DEB)) dut (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .SW      (SW),
    .KEYb    (KEYb),
    .EXTRN   (EXTRN),
    .DONE    (DONE),
    .INSTR   (INSTR),
    .RUN     (RUN),
    .BUSY    (BUSY),
    .BUS_OUT (BUS_OUT),
    .BUS_EN  (BUS_EN),
    .OVR     (OVR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Every RUN pulse must match the oldest accepted press.
  always @(negedge CLK) begin
    if (RUN) begin
      if (exp_q.size() == 0) begin
        checkOutput("run_unexpected", 32'(RUN), 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        checkOutput("instr_sb", 32'(INSTR), 32'(sb_exp));
      end
    end
  end

  // Clean press with settled switches. Edge 0 is the first edge sampling
  // KEYb=0; an accepted press must give RUN exactly in the cycle after edge 7.
  task automatic applyStimulus(input logic [9:0] sw_val, input bit accept,
                               input bit done_in_issue);
    int run_cnt;
    int run_edge;
    run_cnt  = 0;
    run_edge = -1;
    SW = sw_val;
    tick(3);
    if (accept) exp_q.push_back(sw_val);
    KEYb = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(negedge CLK);
      if (RUN) begin
        run_cnt++;
        if (run_edge < 0) run_edge = e;
      end
      if (accept && e == 7) begin
        checkOutput("busy_at_run", 32'(BUSY), 32'd1);
        checkOutput("ovr_at_run", 32'(OVR), 32'd0);
        if (done_in_issue) DONE = 1'b1;
      end
      if (done_in_issue && e == 8) begin
        DONE = 1'b0;
        checkOutput("busy_after_issue_done", 32'(BUSY), 32'd1);
      end
    end
    checkOutput("run_count", 32'(run_cnt), accept ? 32'd1 : 32'd0);
    if (accept) checkOutput("run_edge", 32'(run_edge), 32'd7);
    KEYb = 1'b1;
    tick(DEB + 4);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_instr"},  32'(INSTR),   32'd0);
    checkOutput({tag, "_run"},    32'(RUN),     32'd0);
    checkOutput({tag, "_busy"},   32'(BUSY),    32'd0);
    checkOutput({tag, "_ovr"},    32'(OVR),     32'd0);
    checkOutput({tag, "_bus_en"}, 32'(BUS_EN),  32'd0);
    checkOutput({tag, "_bus"},    32'(BUS_OUT), 32'd0);
  endtask

  logic bounce_pat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    RSTb  = 1'b0;
    KEYb  = 1'b1;
    SW    = '0;
    EXTRN = 1'b0;
    DONE  = 1'b0;
    tick(3);
    checkAllZero("reset");
    RSTb = 1'b1;
    tick(2);

    // Bounce: never four consecutive low samples, so no press.
    for (int i = 0; i < 7; i++) begin
      KEYb = bounce_pat[i];
      tick(1);
    end
    KEYb = 1'b1;
    tick(12);
    checkOutput("bounce_instr", 32'(INSTR), 32'd0);
    checkOutput("bounce_busy", 32'(BUSY), 32'd0);

    // Clean press.
    applyStimulus(10'h2A5, 1'b1, 1'b0);
    checkOutput("press_instr", 32'(INSTR), 32'h2A5);
    checkOutput("press_busy", 32'(BUSY), 32'd1);

    // Bus drive in WAIT follows EXTRN combinationally.
    SW = 10'h155;
    tick(3);
    EXTRN = 1'b1;
    #1;
    checkOutput("wait_bus_en", 32'(BUS_EN), 32'd1);
    checkOutput("wait_bus_out", 32'(BUS_OUT), 32'h155);
    EXTRN = 1'b0;
    #1;
    checkOutput("wait_bus_en_off", 32'(BUS_EN), 32'd0);
    checkOutput("wait_bus_out_off", 32'(BUS_OUT), 32'h000);
    tick(1);

    // Overrun: press while busy is dropped.
    applyStimulus(10'h0F0, 1'b0, 1'b0);
    checkOutput("ovr_set", 32'(OVR), 32'd1);
    checkOutput("ovr_instr_kept", 32'(INSTR), 32'h2A5);
    checkOutput("ovr_busy", 32'(BUSY), 32'd1);

    // DONE in WAIT, with EXTRN high: bus drops together with BUSY.
    EXTRN = 1'b1;
    DONE  = 1'b1;
    #1;
    checkOutput("pre_done_bus_en", 32'(BUS_EN), 32'd1);
    tick(1);
    DONE = 1'b0;
    checkOutput("done_busy", 32'(BUSY), 32'd0);
    checkOutput("done_bus_en", 32'(BUS_EN), 32'd0);
    checkOutput("idle_bus_out", 32'(BUS_OUT), 32'h000);
    checkOutput("ovr_sticky_idle", 32'(OVR), 32'd1);
    EXTRN = 1'b0;

    // New press clears OVR; DONE during the RUN cycle is ignored.
    applyStimulus(10'h3C3, 1'b1, 1'b1);
    checkOutput("press2_instr", 32'(INSTR), 32'h3C3);
    DONE = 1'b1;
    tick(1);
    DONE = 1'b0;
    checkOutput("done2_busy", 32'(BUSY), 32'd0);

    // DONE in IDLE changes nothing.
    DONE = 1'b1;
    tick(2);
    DONE = 1'b0;
    checkOutput("idle_done_busy", 32'(BUSY), 32'd0);
    checkOutput("idle_done_instr", 32'(INSTR), 32'h3C3);
    checkOutput("idle_done_run", 32'(RUN), 32'd0);

    // Reset in the middle of WAIT with OVR set and EXTRN high.
    applyStimulus(10'h1AB, 1'b1, 1'b0);
    applyStimulus(10'h0F0, 1'b0, 1'b0);
    checkOutput("pre_reset_ovr", 32'(OVR), 32'd1);
    EXTRN = 1'b1;
    #1;
    checkOutput("pre_reset_bus_en", 32'(BUS_EN), 32'd1);
    RSTb = 1'b0;
    tick(1);
    RSTb = 1'b1;
    checkAllZero("midreset");
    EXTRN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      DONE = 1'b1;
      tick(1);
      DONE = 1'b0;
      tick(1);
      checkOutput("post_reset_busy", 32'(BUSY), 32'd0);
      checkOutput("post_reset_run", 32'(RUN), 32'd0);
    end

    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
